// File: rtl/delay_line_pkg.sv
// rtl/delay_line_pkg.sv - depth clamp and popcount helpers for prog_delay_line
package delay_line_pkg;

  // Widest valid vector popcount() accepts; MAX_DEPTH must not exceed this.
  localparam int POP_MAX_W = 64;

  function automatic int clamp_depth(input int sel, input int max_depth);
    if (sel == 0)
      return 1;
    else if (sel > max_depth)
      return max_depth;
    else
      return sel;
  endfunction

  function automatic int popcount(input logic [POP_MAX_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++)
      n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one valid+data register stage, priority rst > flush > en
module pipe_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (en) begin
      r_valid <= d_valid;
      r_data  <= d_data;
    end
  end

  assign q_valid = r_valid;
  assign q_data  = r_data;

endmodule

// File: rtl/prog_delay_line.sv
// rtl/prog_delay_line.sv - register chain with runtime-selectable tap, stall and flush
module prog_delay_line
  import delay_line_pkg::*;
#(
  parameter  int WIDTH     = 4,
  parameter  int MAX_DEPTH = 8,
  localparam int DSEL_W    = $clog2(MAX_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [DSEL_W-1:0] depth_sel,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic [DSEL_W-1:0] occupancy,
  output logic              busy
);

  logic [MAX_DEPTH-1:0] w_valid;
  logic [WIDTH-1:0]     w_data [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] w_mask;
  int                   w_eff;

  for (genvar k = 0; k < MAX_DEPTH; k++) begin : g_stage
    logic             w_d_valid;
    logic [WIDTH-1:0] w_d_data;

    // Invalid beats enter with zeroed data so stale values never leak out.
    if (k == 0) begin : g_head
      assign w_d_valid = in_valid;
      assign w_d_data  = in_valid ? in_data : '0;
    end else begin : g_body
      assign w_d_valid = w_valid[k-1];
      assign w_d_data  = w_data[k-1];
    end

    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .flush   (flush),
      .d_valid (w_d_valid),
      .d_data  (w_d_data),
      .q_valid (w_valid[k]),
      .q_data  (w_data[k])
    );
  end

  assign w_eff = clamp_depth(int'(depth_sel), MAX_DEPTH);

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    w_mask    = '0;
    for (int k = 0; k < MAX_DEPTH; k++) begin
      w_mask[k] = (k < w_eff);
      if (k == w_eff - 1) begin
        out_valid = w_valid[k];
        out_data  = w_data[k];
      end
    end
    occupancy = DSEL_W'(popcount(POP_MAX_W'(w_valid & w_mask)));
  end

  assign busy = (occupancy != '0);

endmodule

// File: tb/tb_prog_delay_line.sv
// tb/tb_prog_delay_line.sv - table vectors plus queue scoreboard for prog_delay_line
module tb_prog_delay_line;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [3:0] depth_sel = 4'd3;
  logic       out_valid;
  logic [7:0] out_data;
  logic [3:0] occupancy;
  logic       busy;

  prog_delay_line #(.WIDTH(8), .MAX_DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .depth_sel (depth_sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .occupancy (occupancy),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input int ev, input int ed, input int eocc);
    chk({name, ".out_valid"}, 32'(out_valid), 32'(ev));
    chk({name, ".out_data"},  32'(out_data),  32'(ed));
    chk({name, ".occupancy"}, 32'(occupancy), 32'(eocc));
    chk({name, ".busy"},      32'(busy),      32'(eocc != 0));
  endtask

  typedef struct {
    logic       en, fl, iv;
    logic [7:0] din;
    logic [3:0] dsel;
    logic       ov;
    logic [7:0] od;
    logic [3:0] occ;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input int e, input int f, input int v, input int d, input int s,
                         input int ov, input int od, input int occ);
    vec_t x;
    x.en = (e != 0); x.fl = (f != 0); x.iv = (v != 0);
    x.din = 8'(d); x.dsel = 4'(s);
    x.ov = (ov != 0); x.od = 8'(od); x.occ = 4'(occ);
    tbl.push_back(x);
  endtask

  typedef struct packed {
    logic       v;
    logic [7:0] d;
  } beat_t;

  beat_t sb_q[$];
  beat_t sb_cur;
  int    sb_depth = 1;

  // Queue holds stages 0..depth-2 (back = stage 0); sb_cur is the tap stage.
  task automatic sb_reset(input int d);
    sb_q.delete();
    for (int i = 0; i < d - 1; i++) sb_q.push_back(9'h0);
    sb_cur   = 9'h0;
    sb_depth = d;
  endtask

  task automatic sb_drive(input string name, input int e, input int f, input int v, input int d);
    int occ;
    en = (e != 0); flush = (f != 0); in_valid = (v != 0); in_data = 8'(d);
    @(posedge clk);
    #1;
    if (f != 0) begin
      sb_reset(sb_depth);
    end else if (e != 0) begin
      sb_q.push_back({in_valid, in_valid ? in_data : 8'h00});
      sb_cur = sb_q.pop_front();
    end
    occ = int'(sb_cur.v);
    foreach (sb_q[i]) occ += int'(sb_q[i].v);
    check_out(name, int'(sb_cur.v), int'(sb_cur.d), occ);
  endtask

  initial begin
    #1;
    check_out("reset", 0, 0, 0);
    #11 rst = 1'b0;

    // basic delay at depth 3, then flush priority
    add_vec(1, 0, 1, 'h11, 3, 0, 'h00, 1);
    add_vec(1, 0, 1, 'h22, 3, 0, 'h00, 2);
    add_vec(1, 0, 1, 'h33, 3, 1, 'h11, 3);
    add_vec(1, 0, 1, 'h44, 3, 1, 'h22, 3);
    add_vec(1, 0, 0, 'h99, 3, 1, 'h33, 2);
    add_vec(1, 0, 0, 'h99, 3, 1, 'h44, 1);
    add_vec(1, 0, 0, 'h00, 3, 0, 'h00, 0);
    add_vec(1, 0, 1, 'hA1, 3, 0, 'h00, 1);
    add_vec(1, 0, 1, 'hA2, 3, 0, 'h00, 2);
    add_vec(1, 0, 1, 'hA3, 3, 1, 'hA1, 3);
    add_vec(1, 1, 1, 'h7E, 3, 0, 'h00, 0);
    add_vec(1, 0, 0, 'h00, 3, 0, 'h00, 0);
    add_vec(1, 0, 0, 'h00, 3, 0, 'h00, 0);
    add_vec(1, 0, 0, 'h00, 3, 0, 'h00, 0);
    add_vec(0, 0, 1, 'h55, 3, 0, 'h00, 0);
    foreach (tbl[i]) begin
      en = tbl[i].en; flush = tbl[i].fl; in_valid = tbl[i].iv;
      in_data = tbl[i].din; depth_sel = tbl[i].dsel;
      @(posedge clk);
      #1;
      check_out($sformatf("tbl%0d", i), int'(tbl[i].ov), int'(tbl[i].od), int'(tbl[i].occ));
    end

    // clamp: depth_sel=0 acts as 1
    depth_sel = 4'd0;
    sb_reset(1);
    sb_drive("clamp0_a", 1, 0, 1, 'hA5);
    sb_drive("clamp0_b", 1, 0, 0, 'h00);

    // clamp: depth_sel=15 acts as 8, occupancy reaches 8
    depth_sel = 4'd15;
    sb_reset(8);
    sb_drive("clamp15_fl", 1, 1, 0, 0);
    for (int k = 1; k <= 10; k++) sb_drive($sformatf("clamp15_%0d", k), 1, 0, 1, 'hC0 + k);
    chk("clamp15_peak", 32'(occupancy), 32'd8);

    // stall at depth 4; beats offered while stalled are dropped
    depth_sel = 4'd4;
    sb_reset(4);
    sb_drive("stall_fl", 1, 1, 0, 0);
    sb_drive("stall_b1", 1, 0, 1, 'h01);
    sb_drive("stall_b2", 1, 0, 1, 'h02);
    for (int k = 0; k < 5; k++) sb_drive($sformatf("stall_hold%0d", k), 0, 0, 1, 'hEE);
    sb_drive("stall_b3", 1, 0, 1, 'h03);
    sb_drive("stall_b4", 1, 0, 1, 'h04);
    for (int k = 0; k < 4; k++) sb_drive($sformatf("stall_drain%0d", k), 1, 0, 0, 0);

    // random stream with stalls and occasional flush
    depth_sel = 4'd5;
    sb_reset(5);
    for (int k = 0; k < 60; k++)
      sb_drive($sformatf("rnd%0d", k), int'($urandom_range(0, 3) != 0),
               int'($urandom_range(0, 19) == 0), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 255)));

    // runtime depth change with chain stalled
    depth_sel = 4'd8;
    sb_reset(8);
    sb_drive("dchg_fl", 1, 1, 0, 0);
    for (int k = 0; k < 8; k++) sb_drive($sformatf("dchg_fill%0d", k), 1, 0, 1, 'h10 + k);
    en = 1'b0; in_valid = 1'b0;
    depth_sel = 4'd2;
    #1 check_out("dchg_short", 1, 'h16, 2);
    depth_sel = 4'd8;
    #1 check_out("dchg_long", 1, 'h10, 8);

    // async reset mid-stream
    depth_sel = 4'd3;
    sb_reset(3);
    sb_drive("arst_fl", 1, 1, 0, 0);
    sb_drive("arst_a", 1, 0, 1, 'hAA);
    sb_drive("arst_b", 1, 0, 1, 'hBB);
    chk("arst_busy_before", 32'(busy), 32'd1);
    en = 1'b0; in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_out("arst_during", 0, 0, 0);
    #2 rst = 1'b0;
    sb_reset(3);
    sb_drive("arst_c", 1, 0, 1, 'hCC);
    sb_drive("arst_d1", 1, 0, 0, 0);
    sb_drive("arst_d2", 1, 0, 0, 0);
    chk("arst_latency", 32'(out_data), 32'h0CC);
    sb_drive("arst_d3", 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prog_delay_line.md
Name: prog_delay_line

Overview:
- Parametrised multi-bit register chain with a runtime-selectable tap, a per-stage valid bit, an advance enable (stall) and a synchronous flush.
- Delays a WIDTH-bit data/valid stream by 1..MAX_DEPTH enabled clock cycles.
- Used as a latency-matching and pipeline-balancing element between datapath blocks, where the required delay differs per configuration.

Parameters:
- WIDTH, 4, data bits per stage (>=1)
- MAX_DEPTH, 8, number of physical register stages (>=2)
- DSEL_W, $clog2(MAX_DEPTH+1), width of the depth select (localparam, not overridable)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  advance: when 1, the chain shifts by one stage this cycle
- flush  input  1  synchronous clear of all stages
- in_valid  input  1  qualifier for in_data
- in_data  input  WIDTH  data entering stage 0
- depth_sel  input  DSEL_W  requested delay in stages
- out_valid  output  1  valid bit at the selected tap
- out_data  output  WIDTH  data at the selected tap
- occupancy  output  DSEL_W  count of valid entries in active stages 0..eff_depth-1
- busy  output  1  occupancy != 0

Behaviour:
- Reset (rst=1, async assert, sync release): all stage data = 0 and all stage valid = 0. Therefore out_valid=0, out_data=0, occupancy=0, busy=0 while rst is asserted and until the first enabled shift.
- eff_depth:
  - depth_sel=0 -> 1
  - depth_sel>MAX_DEPTH -> MAX_DEPTH
  - otherwise depth_sel
- Shift, per rising edge with rst=0, flush=0, en=1:
  - stage[0] <= {in_valid, in_data}
  - stage[k] <= stage[k-1] for k = 1..MAX_DEPTH-1
- Stall (en=0, flush=0): every stage holds. in_data/in_valid are ignored (dropped); no back-pressure is provided.
- Flush (flush=1): all valid bits and all data clear to 0 on the next edge. flush has priority over en; the input presented that cycle is dropped.
- Output: out_valid/out_data = stage[eff_depth-1], a combinational mux from registers, with no added register.
  - Latency is exactly eff_depth enabled edges.
  - Invalid beats still propagate with data forced to 0 at entry: stage[0] data <= in_valid ? in_data : 0.
- depth_sel change mid-stream:
  - The tap moves immediately in the same cycle; no stage content is altered.
  - Shortening skips (loses) entries beyond the new tap.
  - Lengthening re-exposes older entries still held in deeper stages. This is documented, intended behaviour.
- occupancy: popcount of valid bits in stages 0..eff_depth-1. It is combinational from registers and depth_sel, with range 0..MAX_DEPTH.
- Stages at index >= eff_depth keep shifting but are not observable.
- Simultaneous rst and flush/en: rst wins.

Decomposition:
- Package delay_line_pkg:
  - clamp_depth(sel) function returning eff_depth
  - popcount helper
- Sub-module pipe_stage(WIDTH): one valid+data register with clk, rst, en and flush, using the same priority rst > flush > en. It is instantiated MAX_DEPTH times in a generate loop.
- Tap mux and occupancy logic stay in the top module.

Test Plan:
1. Reset and basic delay (WIDTH=8, MAX_DEPTH=8, depth_sel=3, en=1): drive in_valid=1 with data 0x11,0x22,0x33,0x44 on consecutive cycles -> out_valid rises 3 edges after the 0x11 edge. out_data reads 0x11,0x22,0x33,0x44, then out_valid=0.
2. Clamping: depth_sel=0 -> 0xA5 appears 1 edge after entry. depth_sel=15 -> appears after 8 edges. occupancy peaks at 8 with continuous valid input.
3. Stall: depth_sel=4, send 0x01..0x04, deassert en for 5 cycles after the second beat -> outputs and occupancy frozen during the stall; total latency = 4 enabled edges; beats presented during the stall never appear.
4. Flush priority: chain holds 3 valid beats, assert flush=1 and en=1 with in_valid=1, in_data=0x7E -> next cycle occupancy=0, out_valid=0, out_data=0, busy=0; 0x7E never appears.
5. Runtime depth change: fill with 0x10..0x17 at depth 8, then set depth_sel=2 with en=0 -> out_data immediately = stage[1] content (0x16). Restore depth 8 -> 0x10 re-exposed.
6. Async reset mid-stream: assert rst between clock edges while busy=1 -> out_valid, out_data, occupancy and busy drop to 0 before the next edge. After release, the first valid beat again takes eff_depth edges.
